// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: response FSM encoding,
// default starvation limit and a counter-width helper.
package dmem_arbiter_pkg;

  typedef logic [1:0] rsp_state_t;

  // Response FSM encoding; values are fixed so other blocks can decode them.
  localparam rsp_state_t StIdle  = 2'd0;
  localparam rsp_state_t StCpuRd = 2'd1;
  localparam rsp_state_t StDbgRd = 2'd2;

  // Maximum consecutive CPU grants while debug waits.
  localparam int unsigned StarveLimDef = 4;

  // Bits needed to hold 0..lim inclusive; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned lim);
    return (lim < 1) ? 1 : $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage, the debug/loader port and the data RAM.
// slave: the arbiter's view. master: the requester/RAM side.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);

  // CPU (MEM stage) port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  // Debug/loader port
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_rvalid;

  // Single-port synchronous RAM
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rdata, dbg_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rdata, dbg_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/rr_starve_ctr.sv
// Saturating starvation counter: counts CPU grants taken while debug waits,
// and flags when debug must be given the next slot.
module rr_starve_ctr #(
  parameter int unsigned STARVE_LIM = 4,
  parameter int unsigned CNT_W      = $clog2(STARVE_LIM + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dbg_req,
  input  logic             dbg_gnt,
  input  logic             cpu_gnt,
  output logic [CNT_W-1:0] cnt,
  output logic             at_limit
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Limit compare on the registered count only, so no path from RAM data.
  always_comb begin
    at_limit = (cnt_q == CNT_W'(STARVE_LIM));
  end

  // Next count: clear when debug is idle or served, else saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (!dbg_req || dbg_gnt) begin
      cnt_d = '0;
    end else if (cpu_gnt && !at_limit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of the data RAM. The CPU has priority except
// when debug has waited STARVE_LIM consecutive CPU grants. Read responses come
// back one cycle after the grant, tracked by a small response FSM.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_LIM = StarveLimDef
) (
  input  logic                             clk,
  input  logic                             rst,
  dmem_arbiter_if.slave                    bus,
  output logic [$clog2(STARVE_LIM+1)-1:0]  starve_cnt
);

  localparam int unsigned CntW = $clog2(STARVE_LIM + 1);

  logic              cpu_gnt;
  logic              dbg_gnt;
  logic              at_limit;
  logic [CntW-1:0]   cnt;
  rsp_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic [DATA_W-1:0] cpu_rdata;
  logic [DATA_W-1:0] dbg_rdata;

  rr_starve_ctr #(
    .STARVE_LIM (STARVE_LIM),
    .CNT_W      (CntW)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .dbg_req  (bus.dbg_req),
    .dbg_gnt  (dbg_gnt),
    .cpu_gnt  (cpu_gnt),
    .cnt      (cnt),
    .at_limit (at_limit)
  );

  assign starve_cnt = cnt;

  // Grant decision; nothing is granted while reset is held.
  always_comb begin
    cpu_gnt = rst & bus.cpu_req & ~(at_limit & bus.dbg_req);
    dbg_gnt = rst & bus.dbg_req & ~cpu_gnt;
  end

  assign bus.cpu_stall = rst & bus.cpu_req & ~cpu_gnt;
  assign bus.dbg_gnt   = dbg_gnt;

  // RAM port steering: winner's command, or an all-zero idle command.
  always_comb begin
    bus.mem_en = 1'b0;
    bus.mem_we = 1'b0;
    addr_sel   = '0;
    wdata_sel  = '0;
    if (cpu_gnt) begin
      bus.mem_en = 1'b1;
      bus.mem_we = bus.cpu_we;
      addr_sel   = bus.cpu_addr;
      wdata_sel  = bus.cpu_wdata;
    end else if (dbg_gnt) begin
      bus.mem_en = 1'b1;
      bus.mem_we = bus.dbg_we;
      addr_sel   = bus.dbg_addr;
      wdata_sel  = bus.dbg_wdata;
    end
  end

  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = wdata_sel;

  // Remember which requester owns the RAM read data next cycle.
  always_comb begin
    state_d = StIdle;
    if (cpu_gnt && !bus.cpu_we) begin
      state_d = StCpuRd;
    end else if (dbg_gnt && !bus.dbg_we) begin
      state_d = StDbgRd;
    end
  end

  // Response state; reset drops any read still in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Route RAM read data to its owner; everyone else sees zero.
  always_comb begin
    bus.cpu_rvalid = 1'b0;
    bus.dbg_rvalid = 1'b0;
    cpu_rdata      = '0;
    dbg_rdata      = '0;
    case (state_q)
      StCpuRd: begin
        bus.cpu_rvalid = 1'b1;
        cpu_rdata      = bus.mem_rdata;
      end
      StDbgRd: begin
        bus.dbg_rvalid = 1'b1;
        dbg_rdata      = bus.mem_rdata;
      end
      default: ;
    endcase
  end

  assign bus.cpu_rdata = cpu_rdata;
  assign bus.dbg_rdata = dbg_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous RAM.
module tb_dmem_arbiter;

  logic       clk;
  logic       rst;
  logic [2:0] starve_cnt;
  logic [31:0] ram [256];
  logic [31:0] ram_q;
  int n_chk;
  int n_bad;

  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  dmem_arbiter #(
    .ADDR_W     (8),
    .DATA_W     (32),
    .STARVE_LIM (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .starve_cnt (starve_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: write in grant cycle, read data valid one cycle later.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            ram_q <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = ram_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drive(input logic req, input logic we, input logic [7:0] a,
                           input logic [31:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic dbg_drive(input logic req, input logic we, input logic [7:0] a,
                           input logic [31:0] d);
    bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
  endtask

  initial begin
    logic [9:0] dbg_pat;
    logic [2:0] cnt_seq [10];
    n_chk = 0;
    n_bad = 0;
    ram_q = '0;
    dbg_pat = 10'b10000_10000;
    cnt_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

    // Reset held with both requests high
    rst = 1'b0;
    cpu_drive(1'b1, 1'b0, 8'h00, 32'h0);
    dbg_drive(1'b1, 1'b0, 8'h00, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_stall", {31'b0, bus.cpu_stall}, 32'd0);
    chk("rst_dbg_gnt", {31'b0, bus.dbg_gnt}, 32'd0);
    chk("rst_mem_en", {31'b0, bus.mem_en}, 32'd0);
    chk("rst_cpu_rvalid", {31'b0, bus.cpu_rvalid}, 32'd0);
    chk("rst_dbg_rvalid", {31'b0, bus.dbg_rvalid}, 32'd0);
    chk("rst_starve_cnt", {29'b0, starve_cnt}, 32'd0);
    next_cycle();
    rst = 1'b1;
    cpu_drive(1'b0, 1'b0, 8'h00, 32'h0);
    dbg_drive(1'b0, 1'b0, 8'h00, 32'h0);
    next_cycle();

    // CPU write then read of 0x10
    cpu_drive(1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_stall", {31'b0, bus.cpu_stall}, 32'd0);
    chk("wr_mem_en", {31'b0, bus.mem_en}, 32'd1);
    chk("wr_mem_we", {31'b0, bus.mem_we}, 32'd1);
    chk("wr_mem_addr", {24'b0, bus.mem_addr}, 32'h10);
    chk("wr_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    next_cycle();
    cpu_drive(1'b1, 1'b0, 8'h10, 32'h0);
    @(negedge clk);
    chk("rd_stall", {31'b0, bus.cpu_stall}, 32'd0);
    chk("rd_no_wr_rvalid", {31'b0, bus.cpu_rvalid}, 32'd0);
    chk("rd_mem_we", {31'b0, bus.mem_we}, 32'd0);
    next_cycle();
    cpu_drive(1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    chk("rd_rvalid", {31'b0, bus.cpu_rvalid}, 32'd1);
    chk("rd_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    chk("idle_mem_en", {31'b0, bus.mem_en}, 32'd0);
    chk("idle_mem_addr", {24'b0, bus.mem_addr}, 32'h0);
    next_cycle();

    // Contention: both reading for 10 cycles
    cpu_drive(1'b1, 1'b0, 8'h10, 32'h0);
    dbg_drive(1'b1, 1'b0, 8'h10, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("cont_stall_%0d", i), {31'b0, bus.cpu_stall}, {31'b0, dbg_pat[i]});
      chk($sformatf("cont_dgnt_%0d", i), {31'b0, bus.dbg_gnt}, {31'b0, dbg_pat[i]});
      if (i > 0) begin
        chk($sformatf("cont_crv_%0d", i), {31'b0, bus.cpu_rvalid}, {31'b0, ~dbg_pat[i-1]});
        chk($sformatf("cont_drv_%0d", i), {31'b0, bus.dbg_rvalid}, {31'b0, dbg_pat[i-1]});
        if (!dbg_pat[i-1]) chk($sformatf("cont_crd_%0d", i), bus.cpu_rdata, 32'hDEADBEEF);
        else               chk($sformatf("cont_drd_%0d", i), bus.dbg_rdata, 32'hDEADBEEF);
      end
      next_cycle();
      chk($sformatf("cont_cnt_%0d", i), {29'b0, starve_cnt}, {29'b0, cnt_seq[i]});
    end
    cpu_drive(1'b0, 1'b0, 8'h00, 32'h0);
    dbg_drive(1'b0, 1'b0, 8'h00, 32'h0);
    next_cycle();

    // Write/read race on 0x20 with the counter at its limit
    cpu_drive(1'b1, 1'b0, 8'h20, 32'h0);
    dbg_drive(1'b1, 1'b1, 8'h20, 32'h12345678);
    repeat (4) next_cycle();
    chk("race_cnt4", {29'b0, starve_cnt}, 32'd4);
    @(negedge clk);
    chk("race_dgnt", {31'b0, bus.dbg_gnt}, 32'd1);
    chk("race_stall", {31'b0, bus.cpu_stall}, 32'd1);
    chk("race_mem_we", {31'b0, bus.mem_we}, 32'd1);
    chk("race_mem_addr", {24'b0, bus.mem_addr}, 32'h20);
    chk("race_mem_wdata", bus.mem_wdata, 32'h12345678);
    next_cycle();
    dbg_drive(1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    chk("retry_stall", {31'b0, bus.cpu_stall}, 32'd0);
    chk("retry_mem_en", {31'b0, bus.mem_en}, 32'd1);
    chk("retry_mem_we", {31'b0, bus.mem_we}, 32'd0);
    chk("retry_drv", {31'b0, bus.dbg_rvalid}, 32'd0);
    chk("retry_cnt", {29'b0, starve_cnt}, 32'd0);
    next_cycle();
    cpu_drive(1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    chk("retry_rvalid", {31'b0, bus.cpu_rvalid}, 32'd1);
    chk("retry_rdata", bus.cpu_rdata, 32'h12345678);
    next_cycle();

    // Debug alone at the top address
    dbg_drive(1'b1, 1'b1, 8'hFF, 32'hA5A50FF0);
    @(negedge clk);
    chk("dwr_gnt", {31'b0, bus.dbg_gnt}, 32'd1);
    chk("dwr_addr", {24'b0, bus.mem_addr}, 32'hFF);
    next_cycle();
    dbg_drive(1'b1, 1'b0, 8'hFF, 32'h0);
    @(negedge clk);
    chk("drd_gnt", {31'b0, bus.dbg_gnt}, 32'd1);
    chk("drd_stall", {31'b0, bus.cpu_stall}, 32'd0);
    chk("drd_addr", {24'b0, bus.mem_addr}, 32'hFF);
    next_cycle();
    dbg_drive(1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    chk("drd_rvalid", {31'b0, bus.dbg_rvalid}, 32'd1);
    chk("drd_rdata", bus.dbg_rdata, 32'hA5A50FF0);
    chk("drd_crv", {31'b0, bus.cpu_rvalid}, 32'd0);
    next_cycle();

    // Reset the cycle after a CPU read grant, with the counter at 2
    cpu_drive(1'b1, 1'b0, 8'h10, 32'h0);
    dbg_drive(1'b1, 1'b0, 8'h10, 32'h0);
    repeat (2) next_cycle();
    chk("mid_cnt2", {29'b0, starve_cnt}, 32'd2);
    rst = 1'b0;
    cpu_drive(1'b0, 1'b0, 8'h00, 32'h0);
    dbg_drive(1'b0, 1'b0, 8'h00, 32'h0);
    #1;
    chk("mid_crv_async", {31'b0, bus.cpu_rvalid}, 32'd0);
    chk("mid_crd_async", bus.cpu_rdata, 32'h0);
    chk("mid_state", {30'b0, dut.state_q}, 32'd0);
    chk("mid_cnt_clr", {29'b0, starve_cnt}, 32'd0);
    @(negedge clk);
    chk("mid_crv", {31'b0, bus.cpu_rvalid}, 32'd0);
    next_cycle();
    rst = 1'b1;
    cpu_drive(1'b1, 1'b0, 8'h10, 32'h0);
    dbg_drive(1'b1, 1'b0, 8'h10, 32'h0);
    @(negedge clk);
    chk("post_rst_stall", {31'b0, bus.cpu_stall}, 32'd0);
    chk("post_rst_dgnt", {31'b0, bus.dbg_gnt}, 32'd0);
    chk("post_rst_crv", {31'b0, bus.cpu_rvalid}, 32'd0);
    next_cycle();
    chk("post_rst_cnt", {29'b0, starve_cnt}, 32'd1);
    cpu_drive(1'b0, 1'b0, 8'h00, 32'h0);
    dbg_drive(1'b0, 1'b0, 8'h00, 32'h0);
    next_cycle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, word address width matching the memory depth of 256 words.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter STARVE_LIM, default 4, maximum number of consecutive CPU grants allowed while a debug request is pending.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-low.
REQ-006 cpu_req, cpu_we  in  1 each  MEM-stage access request and write enable.
REQ-007 cpu_addr  in  ADDR_W; cpu_wdata  in  DATA_W.
REQ-008 cpu_stall  out  1  freezes the pipeline (PC, IF/ID, ID/EX, EX/MEM) while the CPU request is not granted.
REQ-009 cpu_rdata  out  DATA_W; cpu_rvalid  out  1  read data is valid on the cycle after the grant.
REQ-010 dbg_req, dbg_we  in  1 each; dbg_addr  in  ADDR_W; dbg_wdata  in  DATA_W  debug/loader port.
REQ-011 dbg_gnt  out  1; dbg_rdata  out  DATA_W; dbg_rvalid  out  1.
REQ-012 mem_en, mem_we  out  1 each; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  single-port synchronous RAM port.
REQ-013 mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_en with mem_we=0.
REQ-014 starve_cnt  out  $clog2(STARVE_LIM+1)  debug visibility of the starvation counter.

Function
REQ-015 Grant decision is combinational within the request cycle; at most one requester is granted per cycle.
REQ-016 Default priority: the CPU wins whenever cpu_req=1, unless starve_cnt==STARVE_LIM and dbg_req=1, in which case debug wins.
REQ-017 cpu_stall = cpu_req & ~cpu_gnt; dbg_gnt = dbg_req & ~cpu_gnt.
REQ-018 While a requester is granted: mem_en=1, and mem_we/mem_addr/mem_wdata equal that requester's inputs; otherwise mem_en=0, mem_we=0, and address/data are 0.
REQ-019 Response FSM states: IDLE, CPU_RD, DBG_RD; the next state is CPU_RD or DBG_RD after a granted read by that requester, otherwise IDLE.
REQ-020 In CPU_RD: cpu_rvalid=1 and cpu_rdata=mem_rdata. In DBG_RD: dbg_rvalid=1 and dbg_rdata=mem_rdata. In all other cases the rvalid is 0 and the rdata is 0.
REQ-021 Writes complete in the grant cycle and produce no rvalid.
REQ-022 starve_cnt increments, saturating at STARVE_LIM, on each cycle where the CPU is granted while dbg_req=1.
REQ-023 starve_cnt clears on any debug grant and on any cycle with dbg_req=0.
REQ-024 Simultaneous requests to the same address: only the winner accesses; the loser retries, and a read retried after a write returns the new data.
REQ-025 Back-to-back grants are allowed every cycle; the response of grant N coexists with grant N+1.
REQ-026 A requester that deasserts req before being granted is dropped without side effects.
REQ-027 No combinational path exists from mem_rdata to any grant output.

Reset
REQ-028 rst=0 asynchronously forces state IDLE and starve_cnt=0, and drives all rvalid outputs to 0, all rdata outputs to 0, and mem_en/mem_we to 0.
REQ-029 An in-flight read response during reset is discarded; the first grant after release follows REQ-016 with starve_cnt=0.

Structure
REQ-030 The FSM state encoding (IDLE=2'd0, CPU_RD=2'd1, DBG_RD=2'd2) and the default of STARVE_LIM belong in MACRO.v as shared defines.
REQ-031 One sub-module, rr_starve_ctr, holds the saturating starvation counter and its limit compare.
REQ-032 The block sits between the MEM stage and the data RAM; cpu_stall is ORed into the existing LoadStall path by the top level.

Verification
REQ-033 Reset: hold rst=0 with both requests high -> cpu_stall=0, dbg_gnt=0, mem_en=0, and both rvalid outputs 0 while rst=0.
REQ-034 CPU read: CPU write 0xDEADBEEF to addr 0x10, then CPU read 0x10 -> cpu_rvalid=1 next cycle with cpu_rdata=0xDEADBEEF and cpu_stall=0 throughout.
REQ-035 Contention: cpu_req and dbg_req both held high for 10 cycles -> CPU is granted 4 cycles, then debug 1 cycle (cpu_stall=1 that cycle), repeating; starve_cnt sequence is 1,2,3,4,0.
REQ-036 Write/read race: debug write 0x12345678 to 0x20 in the same cycle as a CPU read of 0x20 with starve_cnt=4 -> debug is granted; the CPU retry the next cycle returns 0x12345678.
REQ-037 Debug alone: dbg_req read of 0xFF with cpu_req=0 -> dbg_gnt=1 the same cycle and dbg_rvalid=1 the next cycle; the address wraps correctly at 0xFF.
REQ-038 Reset mid-read: assert rst=0 the cycle after a CPU read grant -> cpu_rvalid stays 0 and the FSM returns to IDLE.
